kernel: RTL and testbench

KERNEL -- requirements
Module: kernel

---
 rtl/kernel.sv | 75 +++++++
 tb/tb_kernel.sv | 109 ++++++++++
 2 files changed

// File: rtl/kernel.sv
// 3x3 image filter: Gaussian, sharpen, high-boost or identity on an 8-bit window,
// producing a registered 16-bit signed result one cycle after the window is sampled.

module kernel_row (
  input  logic [23:0] row,
  output logic [8:0]  ends,
  output logic [7:0]  mid
);
  // Outer pixels of a row are corners (rows 0/2) or left/right edges (row 1).
  assign ends = {1'b0, row[23:16]} + {1'b0, row[7:0]};
  assign mid  = row[15:8];
endmodule

module kernel (
  input  logic               clk,
  input  logic               rst,
  input  logic [23:0]        cache_in [0:2],
  input  logic [1:0]         ksel,
  output logic signed [15:0] kresult
);
  localparam logic [1:0] KS_GAUSS = 2'b00;
  localparam logic [1:0] KS_SHARP = 2'b01;
  localparam logic [1:0] KS_BOOST = 2'b10;
  localparam logic [1:0] KS_IDENT = 2'b11;

  logic [2:0][8:0] ends;
  logic [2:0][7:0] mid;

  for (genvar r = 0; r < 3; r++) begin : g_row
    kernel_row u_row (
      .row  (cache_in[r]),
      .ends (ends[r]),
      .mid  (mid[r])
    );
  end

  logic [7:0]  c;
  logic [9:0]  xsum;
  logic [9:0]  dsum;
  logic [10:0] nsum;
  logic [11:0] gsum;

  assign c    = mid[1];
  assign xsum = {2'b0, mid[0]} + {2'b0, mid[2]} + {1'b0, ends[1]};
  assign dsum = {1'b0, ends[0]} + {1'b0, ends[2]};
  assign nsum = {1'b0, xsum} + {1'b0, dsum};
  // 4C + 2X + D tops out at 4080, so 12 unsigned bits never wrap.
  assign gsum = {2'b0, c, 2'b0} + {1'b0, xsum, 1'b0} + {2'b0, dsum};

  // 14-bit signed covers -2040..2295 with headroom.
  logic signed [13:0] c_s, x_s, n_s;
  logic signed [13:0] sharp, boost, res;

  assign c_s   = signed'({6'b0, c});
  assign x_s   = signed'({4'b0, xsum});
  assign n_s   = signed'({3'b0, nsum});
  assign sharp = (c_s <<< 2) + c_s - x_s;
  assign boost = (c_s <<< 3) + c_s - n_s;

  always_comb begin
    res = '0;
    case (ksel)
      KS_GAUSS: res = signed'({6'b0, gsum[11:4]});
      KS_SHARP: res = sharp;
      KS_BOOST: res = boost;
      KS_IDENT: res = c_s;
      default:  res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) kresult <= '0;
    else     kresult <= {{2{res[13]}}, res};
  end
endmodule

// File: tb/tb_kernel.sv
// Directed bench for kernel: hand-computed results for each filter, extremes,
// per-cycle kernel switching and asynchronous reset behaviour.

module tb_kernel;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [23:0]        cache_in [0:2];
  logic [1:0]         ksel;
  logic signed [15:0] kresult;

  int total = 0;
  int bad   = 0;

  kernel dut (
    .clk      (clk),
    .rst      (rst),
    .cache_in (cache_in),
    .ksel     (ksel),
    .kresult  (kresult)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] exp);
    total++;
    assert (kresult === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, kresult, exp);
    end
  endtask

  // Corners d, edge neighbours e, centre cc.
  task automatic win(input logic [7:0] cc, input logic [7:0] e, input logic [7:0] d);
    cache_in[0] = {d, e, d};
    cache_in[1] = {e, cc, e};
    cache_in[2] = {d, e, d};
  endtask

  initial begin
    win(8'd0, 8'd0, 8'd0);
    ksel = 2'b00;
    #1 rst = 1'b1;
    #1 chk("reset_async", 16'h0000);
    win(8'd11, 8'd11, 8'd11);
    step(); chk("reset_hold0", 16'h0000);
    step(); chk("reset_hold1", 16'h0000);

    rst = 1'b0;
    step(); chk("gauss_11", 16'd11);

    win(8'd15, 8'd11, 8'd11); ksel = 2'b01;
    step(); chk("sharp_31", 16'd31);

    win(8'd22, 8'd11, 8'd11); ksel = 2'b10;
    step(); chk("boost_110", 16'd110);

    win(8'd0, 8'd255, 8'd255); ksel = 2'b10;
    step(); chk("boost_min", 16'hF808);
    ksel = 2'b01;
    step(); chk("sharp_min", 16'hFC04);

    win(8'd255, 8'd0, 8'd0); ksel = 2'b10;
    step(); chk("boost_max", 16'd2295);
    ksel = 2'b00;
    step(); chk("gauss_trunc", 16'd63);
    ksel = 2'b01;
    step(); chk("sharp_max", 16'd1275);

    win(8'd255, 8'd255, 8'd255); ksel = 2'b00;
    step(); chk("gauss_max", 16'd255);

    win(8'd200, 8'd7, 8'd9); ksel = 2'b11;
    step(); chk("ident_200", 16'd200);

    // Edges zero, corners 100: separates X from D.
    win(8'd0, 8'd0, 8'd100); ksel = 2'b01;
    step(); chk("sharp_corners", 16'd0);
    ksel = 2'b10;
    step(); chk("boost_corners", 16'hFE70);
    ksel = 2'b00;
    step(); chk("gauss_corners", 16'd25);

    // Gradient window: X = 200, D = 200, C = 100.
    cache_in[0] = {8'd10, 8'd20, 8'd30};
    cache_in[1] = {8'd40, 8'd100, 8'd60};
    cache_in[2] = {8'd70, 8'd80, 8'd90};
    ksel = 2'b00; step(); chk("switch_gauss", 16'd62);
    ksel = 2'b01; step(); chk("switch_sharp", 16'd300);
    ksel = 2'b10; step(); chk("switch_boost", 16'd500);
    ksel = 2'b11; step(); chk("switch_ident", 16'd100);

    // Mid-cycle reset with a non-zero result held and a new ksel pending.
    ksel = 2'b10;
    #2 rst = 1'b1;
    #1 chk("midreset_async", 16'h0000);
    step(); chk("midreset_hold0", 16'h0000);
    step(); chk("midreset_hold1", 16'h0000);
    rst = 1'b0;
    step(); chk("post_reset", 16'd500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
